// File: rtl/scr1_dmem_router_pkg.sv
// Shared data-memory interface types, dmem port enum and default decode windows.
// Also holds the address decode function used by the router.
package scr1_dmem_router_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_DMEM_PORT0 = 2'd0,
    SCR1_DMEM_PORT1 = 2'd1,
    SCR1_DMEM_PORT2 = 2'd2
  } type_scr1_dmem_port_e;

  localparam logic [31:0] SCR1_DMEM_PORT1_ADDR_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] SCR1_DMEM_PORT1_ADDR_PATTERN = 32'h0048_0000;
  localparam logic [31:0] SCR1_DMEM_PORT2_ADDR_MASK    = 32'hFFFF_FFF0;
  localparam logic [31:0] SCR1_DMEM_PORT2_ADDR_PATTERN = 32'h0049_0000;

  // TCM window takes priority over the timer window when both match.
  function automatic type_scr1_dmem_port_e scr1_dmem_decode(
    input logic [31:0] addr,
    input logic [31:0] p1_mask,
    input logic [31:0] p1_pattern,
    input logic [31:0] p2_mask,
    input logic [31:0] p2_pattern
  );
    if ((addr & p1_mask) == p1_pattern) return SCR1_DMEM_PORT1;
    if ((addr & p2_mask) == p2_pattern) return SCR1_DMEM_PORT2;
    return SCR1_DMEM_PORT0;
  endfunction

endpackage

// File: rtl/scr1_dmem_router_if.sv
// Single-outstanding data-memory request/response bus.
// master drives the request side, slave returns ack and response.
interface scr1_dmem_router_if;
  import scr1_dmem_router_pkg::*;

  logic                 req;
  logic                 req_ack;
  type_scr1_mem_cmd_e   cmd;
  type_scr1_mem_width_e width;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  type_scr1_mem_resp_e  resp;

  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, rdata, resp
  );

  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, rdata, resp
  );

endinterface

// File: rtl/scr1_dmem_router.sv
// Three-way LSU data request router: port1 = TCM, port2 = timer, port0 = AHB bridge.
// Decodes each request once and steers the single outstanding response back to the core.
module scr1_dmem_router
  import scr1_dmem_router_pkg::*;
#(
  parameter logic [31:0] SCR1_PORT1_ADDR_MASK    = SCR1_DMEM_PORT1_ADDR_MASK,
  parameter logic [31:0] SCR1_PORT1_ADDR_PATTERN = SCR1_DMEM_PORT1_ADDR_PATTERN,
  parameter logic [31:0] SCR1_PORT2_ADDR_MASK    = SCR1_DMEM_PORT2_ADDR_MASK,
  parameter logic [31:0] SCR1_PORT2_ADDR_PATTERN = SCR1_DMEM_PORT2_ADDR_PATTERN
) (
  input  logic               rst_n,
  input  logic               clk,
  scr1_dmem_router_if.slave  i_dmem,
  scr1_dmem_router_if.master o_port0,
  scr1_dmem_router_if.master o_port1,
  scr1_dmem_router_if.master o_port2
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } type_fsm_e;

  type_fsm_e            r_fsm;
  type_scr1_dmem_port_e r_port_sel;

  type_scr1_dmem_port_e w_sel;
  type_scr1_mem_resp_e  w_resp_sel;
  logic [31:0]          w_rdata_sel;
  logic                 w_ack_sel;
  logic                 w_can_issue;
  logic                 w_issue;
  logic                 w_req_ack;
  logic                 w_accept;
  type_scr1_mem_resp_e  w_dmem_resp;
  logic [31:0]          w_dmem_rdata;

  assign w_sel = scr1_dmem_decode(i_dmem.addr,
                                  SCR1_PORT1_ADDR_MASK, SCR1_PORT1_ADDR_PATTERN,
                                  SCR1_PORT2_ADDR_MASK, SCR1_PORT2_ADDR_PATTERN);

  always_comb begin
    w_resp_sel  = SCR1_MEM_RESP_NOTRDY;
    w_rdata_sel = '0;
    case (r_port_sel)
      SCR1_DMEM_PORT0: begin w_resp_sel = o_port0.resp; w_rdata_sel = o_port0.rdata; end
      SCR1_DMEM_PORT1: begin w_resp_sel = o_port1.resp; w_rdata_sel = o_port1.rdata; end
      SCR1_DMEM_PORT2: begin w_resp_sel = o_port2.resp; w_rdata_sel = o_port2.rdata; end
      default: begin
        w_resp_sel  = type_scr1_mem_resp_e'('x);
        w_rdata_sel = 'x;
      end
    endcase
  end

  always_comb begin
    w_ack_sel = 1'b0;
    case (w_sel)
      SCR1_DMEM_PORT0: w_ack_sel = o_port0.req_ack;
      SCR1_DMEM_PORT1: w_ack_sel = o_port1.req_ack;
      SCR1_DMEM_PORT2: w_ack_sel = o_port2.req_ack;
      default:         w_ack_sel = 1'bx;
    endcase
  end

  // An error response closes the transaction without allowing a same-cycle issue.
  always_comb begin
    w_can_issue  = 1'b0;
    w_dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    w_dmem_rdata = '0;
    case (r_fsm)
      ST_IDLE: w_can_issue = 1'b1;
      ST_WAIT: begin
        w_can_issue  = (w_resp_sel == SCR1_MEM_RESP_RDY_OK);
        w_dmem_resp  = w_resp_sel;
        w_dmem_rdata = w_rdata_sel;
      end
      default: begin
        w_can_issue  = 1'bx;
        w_dmem_resp  = type_scr1_mem_resp_e'('x);
        w_dmem_rdata = 'x;
      end
    endcase
  end

  // rst_n gating makes port requests drop immediately when reset asserts.
  assign w_issue   = rst_n & w_can_issue;
  assign w_req_ack = w_issue & w_ack_sel;
  assign w_accept  = i_dmem.req & w_req_ack;

  assign i_dmem.req_ack = w_req_ack;
  assign i_dmem.resp    = w_dmem_resp;
  assign i_dmem.rdata   = w_dmem_rdata;

  assign o_port0.req = i_dmem.req & w_issue & (w_sel == SCR1_DMEM_PORT0);
  assign o_port1.req = i_dmem.req & w_issue & (w_sel == SCR1_DMEM_PORT1);
  assign o_port2.req = i_dmem.req & w_issue & (w_sel == SCR1_DMEM_PORT2);

  assign o_port0.cmd   = i_dmem.cmd;
  assign o_port0.width = i_dmem.width;
  assign o_port0.addr  = i_dmem.addr;
  assign o_port0.wdata = i_dmem.wdata;
  assign o_port1.cmd   = i_dmem.cmd;
  assign o_port1.width = i_dmem.width;
  assign o_port1.addr  = i_dmem.addr;
  assign o_port1.wdata = i_dmem.wdata;
  assign o_port2.cmd   = i_dmem.cmd;
  assign o_port2.width = i_dmem.width;
  assign o_port2.addr  = i_dmem.addr;
  assign o_port2.wdata = i_dmem.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= ST_IDLE;
      r_port_sel <= SCR1_DMEM_PORT0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            r_fsm      <= ST_WAIT;
            r_port_sel <= w_sel;
          end
        end
        ST_WAIT: begin
          if (w_accept) begin
            r_port_sel <= w_sel;
          end else if (w_resp_sel != SCR1_MEM_RESP_NOTRDY) begin
            r_fsm <= ST_IDLE;
          end
        end
        default: begin
          r_fsm      <= type_fsm_e'('x);
          r_port_sel <= type_scr1_dmem_port_e'('x);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Scoreboard bench for scr1_dmem_router: expected responses are queued at accept
// and popped when the core side reports a ready response.
module tb_scr1_dmem_router;
  import scr1_dmem_router_pkg::*;

  typedef struct {
    logic [31:0]         rdata;
    type_scr1_mem_resp_e resp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  exp_t e;

  scr1_dmem_router_if dmem_if ();
  scr1_dmem_router_if p0_if ();
  scr1_dmem_router_if p1_if ();
  scr1_dmem_router_if p2_if ();

  scr1_dmem_router dut (
    .rst_n   (rst_n),
    .clk     (clk),
    .i_dmem  (dmem_if),
    .o_port0 (p0_if),
    .o_port1 (p1_if),
    .o_port2 (p2_if)
  );

  logic [2:0] preqs;
  assign preqs = {p2_if.req, p1_if.req, p0_if.req};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int tb_decode(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0048_0000) return 1;
    if ((a & 32'hFFFF_FFF0) == 32'h0049_0000) return 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic req, input type_scr1_mem_cmd_e cmd,
                          input logic [31:0] addr, input logic [31:0] wdata);
    dmem_if.req   = req;
    dmem_if.cmd   = cmd;
    dmem_if.width = SCR1_MEM_WIDTH_WORD;
    dmem_if.addr  = addr;
    dmem_if.wdata = wdata;
  endtask

  task automatic set_port(input int n, input logic ack, input type_scr1_mem_resp_e resp,
                          input logic [31:0] rdata);
    case (n)
      0: begin p0_if.req_ack = ack; p0_if.resp = resp; p0_if.rdata = rdata; end
      1: begin p1_if.req_ack = ack; p1_if.resp = resp; p1_if.rdata = rdata; end
      default: begin p2_if.req_ack = ack; p2_if.resp = resp; p2_if.rdata = rdata; end
    endcase
  endtask

  task automatic quiet();
    set_core(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    for (int n = 0; n < 3; n++) set_port(n, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet();
    @(negedge clk);
    checks++;
    if (preqs !== 3'b000 || dmem_if.req_ack !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got reqs %b ack %b want 000 0", preqs, dmem_if.req_ack);
    end
    checks++;
    if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY || dmem_if.rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got %0d/%h want NOTRDY/0", dmem_if.resp, dmem_if.rdata);
    end
    set_core(1'b1, SCR1_MEM_CMD_RD, 32'h0048_0000, 32'h0);
    set_port(1, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    #1;
    checks++;
    if (preqs !== 3'b000 || dmem_if.req_ack !== 1'b0) begin
      errors++; $display("FAIL reset_gate: got reqs %b ack %b want 000 0", preqs, dmem_if.req_ack);
    end
    tick();
    quiet();
    rst_n = 1'b1;
    tick();
  endtask

  // One request to the decoded port followed by its response in the next cycle.
  task automatic test_single(input string name, input type_scr1_mem_cmd_e cmd,
                             input logic [31:0] addr, input logic [31:0] rdata);
    int n;
    n = tb_decode(addr);
    set_core(1'b1, cmd, addr, ~addr);
    set_port(n, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    @(negedge clk);
    checks++;
    if (preqs !== 3'(1 << n) || dmem_if.req_ack !== 1'b1) begin
      errors++; $display("FAIL %s_req: got reqs %b ack %b want %b 1", name, preqs, dmem_if.req_ack, 3'(1 << n));
    end
    checks++;
    if (p0_if.addr !== addr || p2_if.wdata !== ~addr || p1_if.cmd !== cmd) begin
      errors++; $display("FAIL %s_bcast: got addr %h wdata %h want %h %h", name, p0_if.addr, p2_if.wdata, addr, ~addr);
    end
    if (dmem_if.req && dmem_if.req_ack) sb_q.push_back('{rdata, SCR1_MEM_RESP_RDY_OK});
    tick();
    quiet();
    set_port(n, 1'b0, SCR1_MEM_RESP_RDY_OK, rdata);
    for (int m = 0; m < 3; m++) if (m != n) set_port(m, 1'b0, SCR1_MEM_RESP_RDY_ER, 32'h1111_1111);
    @(negedge clk);
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL %s_resp: got no queued entry want one", name);
    end else begin
      e = sb_q.pop_front();
      if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata) begin
        errors++; $display("FAIL %s_resp: got %0d/%h want %0d/%h", name, dmem_if.resp, dmem_if.rdata, e.resp, e.rdata);
      end
    end
    tick();
    quiet();
    @(negedge clk);
    checks++;
    if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY || dmem_if.rdata !== 32'h0) begin
      errors++; $display("FAIL %s_idle: got %0d/%h want NOTRDY/0", name, dmem_if.resp, dmem_if.rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_core(1'b1, SCR1_MEM_CMD_RD, 32'h0048_0020, 32'h0);
    set_port(1, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    @(negedge clk);
    if (dmem_if.req && dmem_if.req_ack) sb_q.push_back('{32'hCAFE_0001, SCR1_MEM_RESP_RDY_OK});
    tick();
    set_core(1'b1, SCR1_MEM_CMD_WR, 32'h0000_1000, 32'hA5A5_A5A5);
    set_port(1, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'hCAFE_0001);
    set_port(0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    @(negedge clk);
    checks++;
    if (preqs !== 3'b001 || dmem_if.req_ack !== 1'b1) begin
      errors++; $display("FAIL b2b_issue: got reqs %b ack %b want 001 1", preqs, dmem_if.req_ack);
    end
    checks++;
    e = sb_q.size() != 0 ? sb_q.pop_front() : '{32'hXXXX_XXXX, SCR1_MEM_RESP_NOTRDY};
    if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata) begin
      errors++; $display("FAIL b2b_tcm_resp: got %0d/%h want %0d/%h", dmem_if.resp, dmem_if.rdata, e.resp, e.rdata);
    end
    if (dmem_if.req && dmem_if.req_ack) sb_q.push_back('{32'h5A5A_5A5A, SCR1_MEM_RESP_RDY_OK});
    tick();
    set_core(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    set_port(1, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'hBAD0_0001);
    set_port(0, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'h5A5A_5A5A);
    @(negedge clk);
    checks++;
    e = sb_q.size() != 0 ? sb_q.pop_front() : '{32'hXXXX_XXXX, SCR1_MEM_RESP_NOTRDY};
    if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata) begin
      errors++; $display("FAIL b2b_ahb_resp: got %0d/%h want %0d/%h", dmem_if.resp, dmem_if.rdata, e.resp, e.rdata);
    end
    tick();
    quiet();
    tick();
  endtask

  task automatic test_notrdy_stall();
    set_core(1'b1, SCR1_MEM_CMD_RD, 32'h0000_2000, 32'h0);
    set_port(0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    @(negedge clk);
    if (dmem_if.req && dmem_if.req_ack) sb_q.push_back('{32'h7777_7777, SCR1_MEM_RESP_RDY_OK});
    tick();
    set_core(1'b1, SCR1_MEM_CMD_RD, 32'h0048_0004, 32'h0);
    set_port(1, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'h0);
    set_port(0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (preqs !== 3'b000 || dmem_if.req_ack !== 1'b0 || dmem_if.resp !== SCR1_MEM_RESP_NOTRDY) begin
        errors++; $display("FAIL stall_c%0d: got reqs %b ack %b resp %0d want 000 0 0", c, preqs, dmem_if.req_ack, dmem_if.resp);
      end
      tick();
    end
    set_port(0, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'h7777_7777);
    set_port(1, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    @(negedge clk);
    checks++;
    e = sb_q.size() != 0 ? sb_q.pop_front() : '{32'hXXXX_XXXX, SCR1_MEM_RESP_NOTRDY};
    if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata || preqs !== 3'b010) begin
      errors++; $display("FAIL stall_release: got %0d/%h reqs %b want %0d/%h 010", dmem_if.resp, dmem_if.rdata, preqs, e.resp, e.rdata);
    end
    if (dmem_if.req && dmem_if.req_ack) sb_q.push_back('{32'h0101_0101, SCR1_MEM_RESP_RDY_OK});
    tick();
    quiet();
    set_port(1, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'h0101_0101);
    @(negedge clk);
    checks++;
    e = sb_q.size() != 0 ? sb_q.pop_front() : '{32'hXXXX_XXXX, SCR1_MEM_RESP_NOTRDY};
    if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata) begin
      errors++; $display("FAIL stall_tcm_resp: got %0d/%h want %0d/%h", dmem_if.resp, dmem_if.rdata, e.resp, e.rdata);
    end
    tick();
    quiet();
    tick();
  endtask

  task automatic test_error_retry();
    int wait_cyc;
    set_core(1'b1, SCR1_MEM_CMD_RD, 32'h0000_3000, 32'h0);
    set_port(0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    @(negedge clk);
    if (dmem_if.req && dmem_if.req_ack) sb_q.push_back('{32'hEEEE_0000, SCR1_MEM_RESP_RDY_ER});
    tick();
    set_port(0, 1'b1, SCR1_MEM_RESP_RDY_ER, 32'hEEEE_0000);
    @(negedge clk);
    checks++;
    e = sb_q.size() != 0 ? sb_q.pop_front() : '{32'hXXXX_XXXX, SCR1_MEM_RESP_NOTRDY};
    if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata) begin
      errors++; $display("FAIL err_resp: got %0d/%h want %0d/%h", dmem_if.resp, dmem_if.rdata, e.resp, e.rdata);
    end
    checks++;
    if (preqs !== 3'b000 || dmem_if.req_ack !== 1'b0) begin
      errors++; $display("FAIL err_no_issue: got reqs %b ack %b want 000 0", preqs, dmem_if.req_ack);
    end
    tick();
    set_port(0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    wait_cyc = 0;
    @(negedge clk);
    while (!dmem_if.req_ack && wait_cyc < 4) begin
      tick();
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (wait_cyc != 0 || preqs !== 3'b001 || dmem_if.resp !== SCR1_MEM_RESP_NOTRDY) begin
      errors++; $display("FAIL err_retry: got delay %0d reqs %b resp %0d want 0 001 0", wait_cyc, preqs, dmem_if.resp);
    end
    if (dmem_if.req && dmem_if.req_ack) sb_q.push_back('{32'h1234_5678, SCR1_MEM_RESP_RDY_OK});
    tick();
    quiet();
    set_port(0, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'h1234_5678);
    @(negedge clk);
    checks++;
    e = sb_q.size() != 0 ? sb_q.pop_front() : '{32'hXXXX_XXXX, SCR1_MEM_RESP_NOTRDY};
    if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata) begin
      errors++; $display("FAIL retry_resp: got %0d/%h want %0d/%h", dmem_if.resp, dmem_if.rdata, e.resp, e.rdata);
    end
    tick();
    quiet();
    tick();
  endtask

  task automatic test_reset_mid();
    set_core(1'b1, SCR1_MEM_CMD_RD, 32'h0048_0100, 32'h0);
    set_port(1, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
    @(negedge clk);
    if (dmem_if.req && dmem_if.req_ack) sb_q.push_back('{32'hBAD0_BAD0, SCR1_MEM_RESP_RDY_OK});
    tick();
    set_port(1, 1'b1, SCR1_MEM_RESP_RDY_ER, 32'hBAD0_BAD0);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY || preqs !== 3'b000 || dmem_if.req_ack !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got resp %0d reqs %b ack %b want 0 000 0", dmem_if.resp, preqs, dmem_if.req_ack);
    end
    tick();
    quiet();
    rst_n = 1'b1;
    set_port(1, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'hBAD0_BAD0);
    @(negedge clk);
    checks++;
    if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY || dmem_if.rdata !== 32'h0 || sb_q.size() != 0) begin
      errors++; $display("FAIL rst_stale: got %0d/%h want NOTRDY/0", dmem_if.resp, dmem_if.rdata);
    end
    tick();
    quiet();
    tick();
  endtask

  // Pipelined traffic: the owning port answers RDY_OK the cycle after its ack,
  // the other ports present random responses that must be ignored.
  task automatic test_random_pipeline();
    logic [31:0] pool [8];
    logic        req, acc;
    logic [31:0] addr, data;
    logic [2:0]  ack_v;
    int          n, pend_port;
    logic        pend_valid;
    logic [31:0] pend_data;
    pool = '{32'h0048_0010, 32'h0048_FFFC, 32'h0049_0004, 32'h0049_000C,
             32'h0049_0010, 32'h0000_0100, 32'h0047_0000, 32'h0049_0000};
    pend_valid = 1'b0;
    pend_port  = 0;
    pend_data  = '0;
    for (int c = 0; c < 60; c++) begin
      req   = ($urandom_range(0, 4) != 0);
      addr  = pool[$urandom_range(0, 7)];
      n     = tb_decode(addr);
      ack_v = 3'($urandom_range(0, 7)) | 3'(1 << $urandom_range(0, 2));
      set_core(req, type_scr1_mem_cmd_e'(1'($urandom_range(0, 1))), addr, $urandom);
      for (int m = 0; m < 3; m++) begin
        if (pend_valid && m == pend_port)
          set_port(m, ack_v[m], SCR1_MEM_RESP_RDY_OK, pend_data);
        else
          set_port(m, ack_v[m], type_scr1_mem_resp_e'(2'($urandom_range(0, 2))), $urandom);
      end
      @(negedge clk);
      checks++;
      if (preqs !== (req ? 3'(1 << n) : 3'b000) || dmem_if.req_ack !== ack_v[n]) begin
        errors++; $display("FAIL rnd_req c%0d: got reqs %b ack %b want %b %b", c, preqs, dmem_if.req_ack, req ? 3'(1 << n) : 3'b000, ack_v[n]);
      end
      checks++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata) begin
          errors++; $display("FAIL rnd_resp c%0d: got %0d/%h want %0d/%h", c, dmem_if.resp, dmem_if.rdata, e.resp, e.rdata);
        end
      end else if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY || dmem_if.rdata !== 32'h0) begin
        errors++; $display("FAIL rnd_idle c%0d: got %0d/%h want NOTRDY/0", c, dmem_if.resp, dmem_if.rdata);
      end
      acc  = req && ack_v[n];
      data = $urandom;
      if (acc) sb_q.push_back('{data, SCR1_MEM_RESP_RDY_OK});
      pend_valid = acc;
      pend_port  = n;
      pend_data  = data;
      tick();
    end
    quiet();
    if (pend_valid) set_port(pend_port, 1'b0, SCR1_MEM_RESP_RDY_OK, pend_data);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (dmem_if.resp !== e.resp || dmem_if.rdata !== e.rdata) begin
        errors++; $display("FAIL rnd_drain: got %0d/%h want %0d/%h", dmem_if.resp, dmem_if.rdata, e.resp, e.rdata);
      end
    end else if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY) begin
      errors++; $display("FAIL rnd_drain: got %0d want NOTRDY", dmem_if.resp);
    end
    tick();
    quiet();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single("tcm_read", SCR1_MEM_CMD_RD, 32'h0048_0010, 32'hDEAD_BEEF);
    test_single("timer_wr", SCR1_MEM_CMD_WR, 32'h0049_0004, 32'h0000_0042);
    test_single("ahb_wr", SCR1_MEM_CMD_WR, 32'h0049_0010, 32'h0000_0000);
    test_back_to_back();
    test_notrdy_stall();
    test_error_retry();
    test_reset_mid();
    test_random_pipeline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
